// File: rtl/quantum_scheduler.sv
// Preemption timer and round-robin process selector: counts a programmable quantum
// while a user process runs, raises int_req on expiry and advances cur_pid on ack.
module quantum_scheduler #(
  parameter int QUANTUM_W       = 16,
  parameter int DEFAULT_QUANTUM = 1000,
  parameter int NPROC           = 4,
  parameter int PID_W           = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 resume,
  input  logic                 halt,
  input  logic                 quantum_we,
  input  logic [QUANTUM_W-1:0] quantum_in,
  input  logic                 active_we,
  input  logic [NPROC-1:0]     active_in,
  input  logic                 int_ack,
  output logic                 int_req,
  output logic [PID_W-1:0]     cur_pid,
  output logic [PID_W-1:0]     next_pid,
  output logic [QUANTUM_W-1:0] count,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_PEND  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [QUANTUM_W-1:0]   count_q, count_d;
  logic [QUANTUM_W-1:0]   quantum_q, quantum_d;
  logic [NPROC-1:0]       mask_q, mask_d;
  logic [PID_W-1:0]       cur_pid_q, cur_pid_d;
  logic [PID_W-1:0]       next_pid_s, idx_s;
  logic                   found_s;
  logic                   int_req_q, busy_q;

  // Round-robin search: first runnable slot after cur_pid, wrapping; else stay put.
  always_comb begin
    next_pid_s = cur_pid_q;
    idx_s      = cur_pid_q;
    found_s    = 1'b0;
    for (int i = 1; i < NPROC; i++) begin
      idx_s = PID_W'((int'(cur_pid_q) + i) % NPROC);
      if (!found_s && mask_q[idx_s]) begin
        next_pid_s = idx_s;
        found_s    = 1'b1;
      end else begin
        found_s    = found_s;
      end
    end
  end

  // Next-state logic; start always reloads the quantum held before any same-cycle write.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    cur_pid_d = cur_pid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          count_d = quantum_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_PAUSE;
        end else if (start) begin
          count_d = quantum_q;
        end else if (!halt && (count_q != {QUANTUM_W{1'b0}})) begin
          count_d = count_q - QUANTUM_W'(1);
          if (count_q == QUANTUM_W'(1)) begin
            state_d = S_PEND;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          count_d = count_q;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_PAUSE;
        end else if (start) begin
          state_d = S_RUN;
          count_d = quantum_q;
        end else if (resume) begin
          state_d = S_RUN;
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_PEND: begin
        if (int_ack) begin
          state_d   = S_IDLE;
          cur_pid_d = next_pid_s;
        end else begin
          state_d   = S_PEND;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = {QUANTUM_W{1'b0}};
      end
    endcase

    if (quantum_we) begin
      quantum_d = (quantum_in == {QUANTUM_W{1'b0}}) ? QUANTUM_W'(1) : quantum_in;
    end else begin
      quantum_d = quantum_q;
    end

    if (active_we) begin
      mask_d = active_in;
    end else begin
      mask_d = mask_q;
    end
  end

  // State and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= {QUANTUM_W{1'b0}};
      quantum_q <= QUANTUM_W'(DEFAULT_QUANTUM);
      mask_q    <= NPROC'(1);
      cur_pid_q <= {PID_W{1'b0}};
      int_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      quantum_q <= quantum_d;
      mask_q    <= mask_d;
      cur_pid_q <= cur_pid_d;
      int_req_q <= (state_d == S_PEND);
      busy_q    <= (state_d == S_RUN) || (state_d == S_PAUSE);
    end
  end

  assign int_req  = int_req_q;
  assign busy     = busy_q;
  assign count    = count_q;
  assign cur_pid  = cur_pid_q;
  assign next_pid = next_pid_s;

endmodule
